// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V control FSM.
// Sequences IF/ID/EX/MEM/WB for the base opcode classes. Every control output is
// decoded combinationally from the state register and the current inputs.
module mc_control_fsm #(
    parameter int ECALL_HALT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    // PC select and write-back select encodings
    localparam logic [1:0] PCS_PC4    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JALR   = 2'b10;
    localparam logic [1:0] WB_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_MDR     = 2'b01;
    localparam logic [1:0] WB_PC4     = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    state_t r_state;
    state_t w_next;

    // State register; reset forces RST immediately so every output drops to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; all outputs default to 0 each cycle.
    always_comb begin
        w_next    = r_state;
        pc_write  = 1'b0;
        pc_source = PCS_PC4;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_or_d    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALUOUT;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_RS2;
        halted    = 1'b0;

        case (r_state)
            S_RST: begin
                w_next = S_IF;
            end

            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    w_next   = S_ID;
                end
            end

            S_ID: begin
                // PC + imm goes into ALUOut for a possible branch/JAL target.
                alu_src_b = SRCB_IMM;
                w_next    = S_EX;
            end

            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_RS2;
                        w_next    = S_WB;
                    end
                    OP_I, OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        w_next    = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                        w_next    = S_MEM;
                    end
                    OP_BRANCH: begin
                        pc_write  = 1'b1;
                        pc_source = bcond ? PCS_ALUOUT : PCS_PC4;
                        w_next    = S_IF;
                    end
                    OP_JAL: begin
                        // Target already sits in ALUOut from ID.
                        w_next = S_WB;
                    end
                    OP_ECALL: begin
                        if ((ECALL_HALT != 0) && halt_req) begin
                            w_next = S_HALT;
                        end else begin
                            pc_write = 1'b1;
                            w_next   = S_IF;
                        end
                    end
                    default: begin
                        // Unknown opcode retires as a no-op.
                        pc_write = 1'b1;
                        w_next   = S_IF;
                    end
                endcase
            end

            S_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        w_next   = S_IF;
                    end
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                w_next    = S_IF;
                case (opcode)
                    OP_LOAD: begin
                        wb_sel = WB_MDR;
                    end
                    OP_JAL: begin
                        wb_sel    = WB_PC4;
                        pc_source = PCS_ALUOUT;
                    end
                    OP_JALR: begin
                        wb_sel    = WB_PC4;
                        pc_source = PCS_JALR;
                        alu_src_a = 1'b1;
                        alu_src_b = SRCB_IMM;
                    end
                    default: begin
                        wb_sel = WB_ALUOUT;
                    end
                endcase
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_next = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the stimulus thread queues the expected
// retirement of each instruction; a monitor pops on every pc_write pulse.
module tb_mc_control_fsm;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond;
    logic       halt_req;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       halted;

    mc_control_fsm #(.ECALL_HALT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .bcond     (bcond),
        .halt_req  (halt_req),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .pc_source (pc_source),
        .ir_write  (ir_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .i_or_d    (i_or_d),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] vec;   // {pc_source, reg_write, wb_sel, alu_a, alu_b, mem_write, i_or_d, mem_read, ir_write}
        int          lat;   // cycles from first IF cycle to the pc_write cycle, inclusive
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_excl  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [1:0] pcs, input logic rw,
                                input logic [1:0] wbs, input logic a, input logic [1:0] b,
                                input logic mw, input logic iod, input int lat);
        exp_t e;
        e.vec  = {pcs, rw, wbs, a, b, mw, iod, 1'b0, 1'b0};
        e.lat  = lat;
        e.name = name;
        return e;
    endfunction

    function automatic logic [14:0] all_outs();
        return {pc_write, pc_source, ir_write, mem_read, mem_write, i_or_d,
                reg_write, wb_sel, alu_src_a, alu_src_b, halted};
    endfunction

    // Monitor: measure latency from the first IF cycle and check each retirement.
    initial begin
        bit   in_instr = 0;
        int   cnt = 0;
        exp_t e;
        logic [12:0] act;
        forever begin
            @(negedge clk);
            if (mem_read && mem_write) n_excl++;
            if (!reset) begin
                in_instr = 0;
                cnt = 0;
            end else begin
                if (!in_instr && mem_read && !i_or_d) begin
                    in_instr = 1;
                    cnt = 0;
                end
                if (in_instr) cnt++;
                if (pc_write) begin
                    if (sb.size() == 0) begin
                        check("spurious_pc_write", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        act = {pc_source, reg_write, wb_sel, alu_src_a, alu_src_b,
                               mem_write, i_or_d, mem_read, ir_write};
                        check({e.name, "_outs"}, {19'd0, act}, {19'd0, e.vec});
                        check({e.name, "_latency"}, cnt, e.lat);
                    end
                    in_instr = 0;
                end
            end
        end
    end

    // Run one instruction from its first IF cycle; caller sits at posedge+1 of that cycle.
    task automatic run(input logic [6:0] op, input logic bc, input logic hr,
                       input int if_w, input int mem_w, input int base_lat,
                       input bit push, input exp_t e);
        int total;
        total = base_lat + if_w + mem_w;
        if (push) begin
            e.lat = total;
            sb.push_back(e);
        end
        for (int k = 0; k < total; k++) begin
            opcode    = op;
            bcond     = bc;
            halt_req  = hr;
            mem_ready = (k == if_w) || (k == if_w + 3 + mem_w);
            #1;
            if ((op == OP_LOAD || op == OP_STORE) && k >= if_w + 3 && k <= if_w + 3 + mem_w)
                check({e.name, "_mem_phase"}, {mem_read, mem_write, i_or_d},
                      (op == OP_LOAD) ? 3'b101 : 3'b011);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t none;
        none = mk("none", 2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        reset = 1'b0; opcode = 7'd0; bcond = 1'b0; halt_req = 1'b0; mem_ready = 1'b1;

        // Reset state: everything quiet while held
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {17'd0, all_outs()}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_if_after_reset", {mem_read, i_or_d}, 2'b10);

        run(OP_R,      0, 0, 0, 0, 4, 1, mk("r_type",    2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 0));
        run(OP_I,      0, 0, 0, 0, 4, 1, mk("i_type",    2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 0));
        run(OP_BRANCH, 1, 0, 0, 0, 3, 1, mk("br_taken",  2'b01, 0, 2'b00, 0, 2'b00, 0, 0, 0));
        run(OP_BRANCH, 0, 0, 0, 0, 3, 1, mk("br_not",    2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0));
        run(OP_LOAD,   0, 0, 0, 0, 5, 1, mk("load",      2'b00, 1, 2'b01, 0, 2'b00, 0, 0, 0));
        run(OP_LOAD,   0, 0, 0, 3, 5, 1, mk("load_wait", 2'b00, 1, 2'b01, 0, 2'b00, 0, 0, 0));
        run(OP_STORE,  0, 0, 0, 1, 4, 1, mk("store",     2'b00, 0, 2'b00, 0, 2'b00, 1, 1, 0));
        run(OP_JAL,    0, 0, 0, 0, 4, 1, mk("jal",       2'b01, 1, 2'b10, 0, 2'b00, 0, 0, 0));
        run(OP_JALR,   0, 0, 0, 0, 4, 1, mk("jalr",      2'b10, 1, 2'b10, 1, 2'b10, 0, 0, 0));
        run(OP_ECALL,  0, 0, 0, 0, 3, 1, mk("ecall_nop", 2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0));
        run(OP_BAD,    1, 1, 0, 0, 3, 1, mk("unknown",   2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0));
        run(OP_R,      0, 0, 2, 0, 4, 1, mk("r_if_wait", 2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 0));

        // ECALL halt: no retirement expected, HALT holds for 20 cycles
        run(OP_ECALL, 0, 1, 0, 0, 3, 0, none);
        check("halt_entry", {17'd0, all_outs()}, 32'd1);
        for (int k = 0; k < 20; k++) begin
            mem_ready = k[0];
            @(posedge clk);
        end
        #1;
        check("halt_sticky", {17'd0, all_outs()}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("halt_cleared_async", {17'd0, all_outs()}, 32'd0);

        // Store aborted by reset during a MEM wait
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        opcode = OP_STORE; mem_ready = 1'b1; halt_req = 1'b0;
        @(posedge clk); #1; mem_ready = 1'b0;   // ID
        @(posedge clk); #1;                      // EX
        @(posedge clk); #1;                      // MEM wait
        check("store_wait_mem_write", {mem_write, i_or_d}, 2'b11);
        @(posedge clk); #2;                      // still waiting
        reset = 1'b0;
        #1;
        check("store_abort_async", {17'd0, all_outs()}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("if_after_abort", {mem_read, i_or_d, pc_write}, 3'b100);
        run(OP_R, 0, 0, 0, 0, 4, 1, mk("r_after_abort", 2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 0));

        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("mem_rw_exclusive", n_excl, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
